fetch_bpred: RTL and testbench

- Instruction-fetch front end that sources the PC for the combinational instruction ROM and captures the returned instruction word into the IF/ID pipeline register.
- Predicts the next PC with a direct-mapped branch target buffer (BTB). Each entry holds a 2-bit saturating counter.
- The execute stage trains the BTB through an update port and recovers from mispredictions through a redirect port.

---
 rtl/fetch_bpred_if.sv | 32 +++
 rtl/fetch_bpred.sv | 114 +++++++++++
 tb/tb_fetch_bpred.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_bpred_if.sv
// Fetch front-end bus: ROM address/data, IF/ID register outputs,
// EX-stage redirect and BTB training ports.
interface fetch_bpred_if;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] instr_in;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  // Pipeline / ROM side: drives control, training and instruction data
  modport master (
    output stall, instr_in, redirect, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target,
    input  pc, if_pc, if_instr, if_valid, if_pred_taken, if_pred_target
  );

  // Fetch unit side
  modport slave (
    input  stall, instr_in, redirect, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target,
    output pc, if_pc, if_instr, if_valid, if_pred_taken, if_pred_target
  );
endinterface

// File: rtl/fetch_bpred.sv
// Instruction fetch with a direct-mapped BTB holding 2-bit saturating
// counters. Lookup is combinational on the current pc; training and
// redirect come from the execute stage.
module fetch_bpred #(
  parameter int          BTB_IDX_W = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_bpred_if.slave  bus
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 32 - BTB_IDX_W - 2;

  logic                 btb_valid  [ENTRIES];
  logic [TAG_W-1:0]     btb_tag    [ENTRIES];
  logic [31:0]          btb_target [ENTRIES];
  logic [1:0]           btb_ctr    [ENTRIES];

  logic [31:0]          pc_q;
  logic [31:0]          if_pc_q;
  logic [31:0]          if_instr_q;
  logic                 if_valid_q;
  logic                 if_pred_taken_q;
  logic [31:0]          if_pred_target_q;

  logic [BTB_IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_hit;
  logic                 pred_taken;
  logic [31:0]          next_pc;

  logic [BTB_IDX_W-1:0] up_idx;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit;
  logic                 unused_upd_low;

  assign lk_idx = pc_q[BTB_IDX_W+1:2];
  assign lk_tag = pc_q[31:BTB_IDX_W+2];
  assign up_idx = bus.upd_pc[BTB_IDX_W+1:2];
  assign up_tag = bus.upd_pc[31:BTB_IDX_W+2];

  // Word-aligned branches only; the byte offset of upd_pc carries no information
  assign unused_upd_low = ^bus.upd_pc[1:0];

  // Predict the next fetch address from the pre-edge BTB contents
  always_comb begin
    lk_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    pred_taken = lk_hit && btb_ctr[lk_idx][1];
    next_pc    = pred_taken ? btb_target[lk_idx] : pc_q + 32'd4;
    up_hit     = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
  end

  // PC and IF/ID register: reset beats redirect, redirect beats stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      if_pc_q          <= '0;
      if_instr_q       <= '0;
      if_valid_q       <= 1'b0;
      if_pred_taken_q  <= 1'b0;
      if_pred_target_q <= '0;
    end else if (bus.redirect) begin
      pc_q             <= bus.redirect_pc;
      if_pc_q          <= '0;
      if_instr_q       <= '0;
      if_valid_q       <= 1'b0;
      if_pred_taken_q  <= 1'b0;
      if_pred_target_q <= '0;
    end else if (!bus.stall) begin
      pc_q             <= next_pc;
      if_pc_q          <= pc_q;
      if_instr_q       <= bus.instr_in;
      if_valid_q       <= 1'b1;
      if_pred_taken_q  <= pred_taken;
      if_pred_target_q <= next_pc;
    end
  end

  // BTB training: counters move on hits, only taken branches allocate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b00;
      end
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          btb_target[up_idx] <= bus.upd_target;
          if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
        end else if (btb_ctr[up_idx] != 2'b00) begin
          btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        btb_valid[up_idx]  <= 1'b1;
        btb_tag[up_idx]    <= up_tag;
        btb_target[up_idx] <= bus.upd_target;
        btb_ctr[up_idx]    <= 2'b10;
      end
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pred_taken  = if_pred_taken_q;
  assign bus.if_pred_target = if_pred_target_q;

endmodule

// File: tb/tb_fetch_bpred.sv
// Directed bench for fetch_bpred: sequential fetch, BTB allocation and
// counter behaviour, stall, redirect, aliasing, mid-stream reset.
module tb_fetch_bpred;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   fails = 0;

  fetch_bpred_if bus ();

  fetch_bpred #(.BTB_IDX_W(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  assign bus.instr_in = rom(bus.pc);

  // Advance one clock; outputs are sampled 1 ns after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_update(input logic [31:0] a, input logic t, input logic [31:0] tgt);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = a;
    bus.upd_taken  = t;
    bus.upd_target = tgt;
    tick();
    bus.upd_valid  = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    bus.redirect    = 1'b1;
    bus.redirect_pc = a;
    tick();
    bus.redirect    = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++; if (bus.pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_pc got %h want %h", bus.pc, 32'h0); end
    tests_run++; if (bus.if_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", bus.if_valid); end
    tests_run++; if (bus.if_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_if_pc got %h want 0", bus.if_pc); end
    tests_run++; if (bus.if_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_if_instr got %h want 0", bus.if_instr); end
    tests_run++; if (bus.if_pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL reset_pred got %b want 0", bus.if_pred_taken); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 32'(4 * (i + 1));
      tests_run++; if (bus.pc !== exp_pc) begin fails++; $display("[TB] FAIL seq_pc[%0d] got %h want %h", i, bus.pc, exp_pc); end
      tests_run++; if (bus.if_pc !== exp_pc - 32'd4) begin fails++; $display("[TB] FAIL seq_if_pc[%0d] got %h want %h", i, bus.if_pc, exp_pc - 32'd4); end
      tests_run++; if (bus.if_instr !== rom(exp_pc - 32'd4)) begin fails++; $display("[TB] FAIL seq_instr[%0d] got %h want %h", i, bus.if_instr, rom(exp_pc - 32'd4)); end
      tests_run++; if (bus.if_valid !== 1'b1) begin fails++; $display("[TB] FAIL seq_valid[%0d] got %b want 1", i, bus.if_valid); end
      tests_run++; if (bus.if_pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL seq_pred[%0d] got %b want 0", i, bus.if_pred_taken); end
      tests_run++; if (bus.if_pred_target !== exp_pc) begin fails++; $display("[TB] FAIL seq_target[%0d] got %h want %h", i, bus.if_pred_target, exp_pc); end
    end
  endtask

  task automatic test_alloc;
    do_reset();
    send_update(32'h10, 1'b1, 32'h40);
    tests_run++; if (bus.pc !== 32'h4) begin fails++; $display("[TB] FAIL alloc_pc0 got %h want 4", bus.pc); end
    tick(); tick(); tick();
    tests_run++; if (bus.pc !== 32'h10) begin fails++; $display("[TB] FAIL alloc_reach got %h want 10", bus.pc); end
    tick();
    tests_run++; if (bus.pc !== 32'h40) begin fails++; $display("[TB] FAIL alloc_next got %h want 40", bus.pc); end
    tests_run++; if (bus.if_pc !== 32'h10) begin fails++; $display("[TB] FAIL alloc_if_pc got %h want 10", bus.if_pc); end
    tests_run++; if (bus.if_pred_taken !== 1'b1) begin fails++; $display("[TB] FAIL alloc_pred got %b want 1", bus.if_pred_taken); end
    tests_run++; if (bus.if_pred_target !== 32'h40) begin fails++; $display("[TB] FAIL alloc_target got %h want 40", bus.if_pred_target); end
    tick();
    tests_run++; if (bus.pc !== 32'h44) begin fails++; $display("[TB] FAIL alloc_after got %h want 44", bus.pc); end
  endtask

  task automatic test_counter;
    do_reset();
    send_update(32'h10, 1'b1, 32'h40);          // 10
    send_update(32'h10, 1'b0, 32'h0);           // 01
    redirect_to(32'h10); tick();
    tests_run++; if (bus.pc !== 32'h14) begin fails++; $display("[TB] FAIL ctr01_pc got %h want 14", bus.pc); end
    tests_run++; if (bus.if_pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL ctr01_pred got %b want 0", bus.if_pred_taken); end
    send_update(32'h10, 1'b0, 32'h0);           // 00
    send_update(32'h10, 1'b0, 32'h0);           // 00 (floor)
    send_update(32'h10, 1'b1, 32'h40);          // 01
    redirect_to(32'h10); tick();
    tests_run++; if (bus.pc !== 32'h14) begin fails++; $display("[TB] FAIL ctr_floor_pc got %h want 14", bus.pc); end
    send_update(32'h10, 1'b1, 32'h40);          // 10
    send_update(32'h10, 1'b1, 32'h40);          // 11
    send_update(32'h10, 1'b1, 32'h80);          // 11 (ceiling), target 80
    send_update(32'h10, 1'b0, 32'h0);           // 10
    redirect_to(32'h10); tick();
    tests_run++; if (bus.pc !== 32'h80) begin fails++; $display("[TB] FAIL ctr_ceil_pc got %h want 80", bus.pc); end
    tests_run++; if (bus.if_pred_taken !== 1'b1) begin fails++; $display("[TB] FAIL ctr_ceil_pred got %b want 1", bus.if_pred_taken); end
    send_update(32'h10, 1'b0, 32'h0);           // 01
    redirect_to(32'h10); tick();
    tests_run++; if (bus.pc !== 32'h14) begin fails++; $display("[TB] FAIL ctr_down_pc got %h want 14", bus.pc); end
  endtask

  task automatic test_stall;
    do_reset();
    tick(); tick();
    bus.stall = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h10; bus.upd_taken = 1'b1; bus.upd_target = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.upd_valid = 1'b0;
      tests_run++; if (bus.pc !== 32'h8) begin fails++; $display("[TB] FAIL stall_pc[%0d] got %h want 8", i, bus.pc); end
      tests_run++; if (bus.if_pc !== 32'h4) begin fails++; $display("[TB] FAIL stall_if_pc[%0d] got %h want 4", i, bus.if_pc); end
      tests_run++; if (bus.if_instr !== rom(32'h4)) begin fails++; $display("[TB] FAIL stall_instr[%0d] got %h want %h", i, bus.if_instr, rom(32'h4)); end
      tests_run++; if (bus.if_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, bus.if_valid); end
    end
    bus.stall = 1'b0;
    tick(); tick();
    tests_run++; if (bus.pc !== 32'h10) begin fails++; $display("[TB] FAIL stall_resume got %h want 10", bus.pc); end
    tick();
    tests_run++; if (bus.pc !== 32'h40) begin fails++; $display("[TB] FAIL stall_btb_write got %h want 40", bus.pc); end
  endtask

  task automatic test_redirect_stall;
    do_reset();
    tick();
    bus.stall = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0; bus.stall = 1'b0;
    tests_run++; if (bus.pc !== 32'h100) begin fails++; $display("[TB] FAIL redir_pc got %h want 100", bus.pc); end
    tests_run++; if (bus.if_valid !== 1'b0) begin fails++; $display("[TB] FAIL redir_valid got %b want 0", bus.if_valid); end
    tests_run++; if (bus.if_pc !== 32'h0) begin fails++; $display("[TB] FAIL redir_if_pc got %h want 0", bus.if_pc); end
    tick();
    tests_run++; if (bus.if_pc !== 32'h100) begin fails++; $display("[TB] FAIL redir_next_if_pc got %h want 100", bus.if_pc); end
    tests_run++; if (bus.if_valid !== 1'b1) begin fails++; $display("[TB] FAIL redir_next_valid got %b want 1", bus.if_valid); end
    tests_run++; if (bus.if_instr !== rom(32'h100)) begin fails++; $display("[TB] FAIL redir_next_instr got %h want %h", bus.if_instr, rom(32'h100)); end
    tests_run++; if (bus.pc !== 32'h104) begin fails++; $display("[TB] FAIL redir_next_pc got %h want 104", bus.pc); end
  endtask

  task automatic test_same_cycle;
    do_reset();
    redirect_to(32'h10);
    send_update(32'h10, 1'b1, 32'h40);
    tests_run++; if (bus.pc !== 32'h14) begin fails++; $display("[TB] FAIL same_cycle_pc got %h want 14", bus.pc); end
    tests_run++; if (bus.if_pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL same_cycle_pred got %b want 0", bus.if_pred_taken); end
    redirect_to(32'h10); tick();
    tests_run++; if (bus.pc !== 32'h40) begin fails++; $display("[TB] FAIL same_cycle_later got %h want 40", bus.pc); end
  endtask

  task automatic test_wrap;
    do_reset();
    redirect_to(32'hFFFF_FFFC); tick();
    tests_run++; if (bus.pc !== 32'h0) begin fails++; $display("[TB] FAIL wrap_pc got %h want 0", bus.pc); end
  endtask

  task automatic test_alias;
    do_reset();
    send_update(32'h50, 1'b1, 32'h200);
    redirect_to(32'h50); tick();
    tests_run++; if (bus.pc !== 32'h200) begin fails++; $display("[TB] FAIL alias_hit got %h want 200", bus.pc); end
    send_update(32'h150, 1'b0, 32'h300);
    redirect_to(32'h50); tick();
    tests_run++; if (bus.pc !== 32'h200) begin fails++; $display("[TB] FAIL alias_nt_keep got %h want 200", bus.pc); end
    redirect_to(32'h150); tick();
    tests_run++; if (bus.pc !== 32'h154) begin fails++; $display("[TB] FAIL alias_nt_noalloc got %h want 154", bus.pc); end
    send_update(32'h150, 1'b1, 32'h300);
    redirect_to(32'h50); tick();
    tests_run++; if (bus.pc !== 32'h54) begin fails++; $display("[TB] FAIL alias_evict got %h want 54", bus.pc); end
    redirect_to(32'h150); tick();
    tests_run++; if (bus.pc !== 32'h300) begin fails++; $display("[TB] FAIL alias_new got %h want 300", bus.pc); end
  endtask

  task automatic test_reset_mid;
    // BTB still holds 0x150 -> 0x300 from the alias test
    redirect_to(32'h40); tick();
    rst = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h700; bus.stall = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h0; bus.upd_taken = 1'b1; bus.upd_target = 32'h500;
    tick();
    rst = 1'b0; bus.redirect = 1'b0; bus.stall = 1'b0; bus.upd_valid = 1'b0;
    tests_run++; if (bus.pc !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_pc got %h want 0", bus.pc); end
    tests_run++; if (bus.if_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid got %b want 0", bus.if_valid); end
    tests_run++; if (bus.if_pc !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_if_pc got %h want 0", bus.if_pc); end
    tick();
    tests_run++; if (bus.pc !== 32'h4) begin fails++; $display("[TB] FAIL rstmid_no_upd got %h want 4", bus.pc); end
    redirect_to(32'h150); tick();
    tests_run++; if (bus.pc !== 32'h154) begin fails++; $display("[TB] FAIL rstmid_btb_clear got %h want 154", bus.pc); end
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.upd_valid   = 1'b0;
    bus.upd_pc      = 32'h0;
    bus.upd_taken   = 1'b0;
    bus.upd_target  = 32'h0;
    test_reset();
    test_sequential();
    test_alloc();
    test_counter();
    test_stall();
    test_redirect_stall();
    test_same_cycle();
    test_wrap();
    test_alias();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
